// File: rtl/core_pkg.sv
// Shared types for the instruction-memory loader.
// IMEM_LOADER_CHECKSUM_EN adds the trailing checksum state.
package core_pkg;

  localparam int WORD_BYTES = 4;

`ifdef IMEM_LOADER_CHECKSUM_EN
  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    WRITE,
    DONE,
    CHECK
  } state_t;
`else
  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    WRITE,
    DONE
  } state_t;
`endif

endpackage

// File: rtl/imem_loader.sv
// Streams program bytes into 32-bit little-endian imem writes.
// IMEM_LOADER_CHECKSUM_EN enables a mod-256 checksum byte after the load.
module imem_loader
  import core_pkg::*;
#(
  parameter int          DEPTH_BYTES = 40,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [7:0]  byte_in,
  input  logic        byte_valid,
  output logic        byte_ready,
  output logic        wr_en,
  output logic [31:0] wr_addr,
  output logic [31:0] wr_data,
  output logic        core_hold,
  output logic        done
`ifdef IMEM_LOADER_CHECKSUM_EN
  ,
  output logic        chk_err
`endif
);

  localparam logic [31:0] LAST_ADDR =
    BASE_ADDR + 32'(DEPTH_BYTES - WORD_BYTES);

  state_t      state;
  state_t      state_nx;
  logic [1:0]  byte_cnt;
  logic [31:0] word;
  logic [31:0] addr;
  logic        last;
  logic        go;

  assign last    = (addr == LAST_ADDR);
  assign go      = start &&
                   (state == IDLE || state == DONE);
  assign wr_addr = addr;
  assign wr_data = word;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx   = state;
    byte_ready = 1'b0;
    wr_en      = 1'b0;
    core_hold  = 1'b1;
    done       = 1'b0;
    unique case (state)
      IDLE: begin
        if (start) state_nx = LOAD;
      end
      LOAD: begin
        byte_ready = 1'b1;
        if (byte_valid && byte_cnt == 2'd3)
          state_nx = WRITE;
      end
      WRITE: begin
        wr_en = 1'b1;
`ifdef IMEM_LOADER_CHECKSUM_EN
        state_nx = last ? CHECK : LOAD;
`else
        state_nx = last ? DONE : LOAD;
`endif
      end
`ifdef IMEM_LOADER_CHECKSUM_EN
      CHECK: begin
        byte_ready = 1'b1;
        if (byte_valid) state_nx = DONE;
      end
`endif
      DONE: begin
        core_hold = 1'b0;
        done      = 1'b1;
        if (start) state_nx = LOAD;
      end
      default: state_nx = IDLE;
    endcase
  end

`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [7:0] sum;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum     <= 8'h00;
      chk_err <= 1'b0;
    end else begin
      if (go) begin
        sum     <= 8'h00;
        chk_err <= 1'b0;
      end
      if (state == LOAD && byte_valid)
        sum <= sum + byte_in;
      if (state == CHECK && byte_valid)
        chk_err <= (byte_in != sum);
    end
  end
`endif

  // Address parks on the last word so it never runs past the memory.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      byte_cnt <= 2'd0;
      word     <= 32'h0;
      addr     <= BASE_ADDR;
    end else begin
      if (go) begin
        byte_cnt <= 2'd0;
        addr     <= BASE_ADDR;
      end
      if (state == LOAD && byte_valid) begin
        word[{byte_cnt, 3'b000} +: 8] <= byte_in;
        byte_cnt <= byte_cnt + 2'd1;
      end
      if (state == WRITE && !last)
        addr <= addr + 32'd4;
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: vector table,
// directed corner sequences and randomized full loads.
module tb_imem_loader;

  localparam int DEPTH = 40;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [7:0]  byte_in = 8'h00;
  logic        byte_valid = 1'b0;
  logic        byte_ready;
  logic        wr_en;
  logic [31:0] wr_addr;
  logic [31:0] wr_data;
  logic        core_hold;
  logic        done;
`ifdef IMEM_LOADER_CHECKSUM_EN
  logic        chk_err;
`endif

  imem_loader #(
    .DEPTH_BYTES(DEPTH),
    .BASE_ADDR  (32'h0000_0000)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .byte_in   (byte_in),
    .byte_valid(byte_valid),
    .byte_ready(byte_ready),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .core_hold (core_hold),
    .done      (done)
`ifdef IMEM_LOADER_CHECKSUM_EN
    ,
    .chk_err   (chk_err)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
  } wr_t;

  typedef struct {
    logic [7:0]  b0, b1, b2, b3;
    logic [31:0] exp;
  } vec_t;

  wr_t        got[$];
  logic [7:0] prog[$];

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h",
               name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n && wr_en) begin
      got.push_back('{wr_addr, wr_data});
      chk("ready_low_in_write", {31'b0, byte_ready}, 32'd0);
    end
  end

  task automatic do_reset();
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_byte_ready", {31'b0, byte_ready}, 32'd0);
    chk("rst_wr_en", {31'b0, wr_en}, 32'd0);
    chk("rst_wr_addr", wr_addr, 32'h0);
    chk("rst_wr_data", wr_data, 32'h0);
    chk("rst_core_hold", {31'b0, core_hold}, 32'd1);
    chk("rst_done", {31'b0, done}, 32'd0);
    start = 1'b0;
    byte_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // mode 0: always valid, 1: toggling but held while stalled, 2: random
  task automatic stream(input int from, input int to,
                        input int mode);
    int i = from;
    int guard = 0;
    logic v;
    while (i < to && guard < 4000) begin
      @(negedge clk);
      guard++;
      if (mode == 0) v = 1'b1;
      else if (mode == 1) v = guard[0] | ~byte_ready;
      else v = 1'($urandom_range(0, 1));
      byte_valid = v;
      byte_in = prog[i];
      if (v && byte_ready) i++;
    end
    @(negedge clk);
    byte_valid = 1'b0;
    if (i < to) chk("stream_timeout", i, to);
  endtask

  task automatic add_checksum();
`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [7:0] s = 8'h00;
    for (int k = 0; k < DEPTH; k++) s = s + prog[k];
    prog.push_back(s);
`endif
  endtask

  task automatic rand_prog();
    prog.delete();
    for (int k = 0; k < DEPTH; k++)
      prog.push_back(8'($urandom));
    add_checksum();
  endtask

  task automatic pattern_prog();
    prog.delete();
    for (int k = 0; k < DEPTH / 4; k++) begin
      prog.push_back(8'h9a);
      prog.push_back(8'hbc);
      prog.push_back(8'hde);
      prog.push_back(8'hf0);
    end
    add_checksum();
  endtask

  task automatic wait_done();
    int n = 0;
    while (!done && n < 300) begin
      @(negedge clk);
      n++;
    end
    chk("done_high", {31'b0, done}, 32'd1);
    chk("core_hold_low", {31'b0, core_hold}, 32'd0);
  endtask

  task automatic check_writes(input string tag);
    int nw = DEPTH / 4;
    chk({tag, "_count"}, got.size(), nw);
    for (int k = 0; k < nw && k < got.size(); k++) begin
      chk({tag, "_addr"}, got[k].addr, 32'(k * 4));
      chk({tag, "_data"}, got[k].data,
          {prog[4*k+3], prog[4*k+2],
           prog[4*k+1], prog[4*k]});
    end
  endtask

  task automatic full_load(input int mode, input string tag);
    got.delete();
    pulse_start();
    stream(0, prog.size(), mode);
    wait_done();
    check_writes(tag);
  endtask

  vec_t vt[4];

  initial begin
    vt[0] = '{8'h12, 8'h34, 8'h56, 8'h78, 32'h7856_3412};
    vt[1] = '{8'h00, 8'h00, 8'h00, 8'h00, 32'h0000_0000};
    vt[2] = '{8'hff, 8'h00, 8'hff, 8'h01, 32'h01ff_00ff};
    vt[3] = '{8'ha5, 8'h5a, 8'hc3, 8'h3c, 32'h3cc3_5aa5};

    for (int t = 0; t < 4; t++) begin
      do_reset();
      prog.delete();
      prog.push_back(vt[t].b0);
      prog.push_back(vt[t].b1);
      prog.push_back(vt[t].b2);
      prog.push_back(vt[t].b3);
      got.delete();
      pulse_start();
      chk("hold_in_load", {31'b0, core_hold}, 32'd1);
      stream(0, 4, 0);
      repeat (2) @(negedge clk);
      chk("vec_count", got.size(), 32'd1);
      if (got.size() > 0) begin
        chk("vec_addr", got[0].addr, 32'h0);
        chk("vec_data", got[0].data, vt[t].exp);
      end
    end

    do_reset();
    pattern_prog();
    full_load(0, "pattern");

    do_reset();
    pattern_prog();
    full_load(1, "toggle");

    for (int r = 0; r < 3; r++) begin
      do_reset();
      rand_prog();
      full_load(2, "random");
    end

    do_reset();
    rand_prog();
    got.delete();
    pulse_start();
    stream(0, 6, 0);
    do_reset();
    byte_valid = 1'b1;
    repeat (10) @(negedge clk);
    byte_valid = 1'b0;
    chk("abort_writes", got.size(), 32'd1);
    chk("abort_idle_ready", {31'b0, byte_ready}, 32'd0);
    rand_prog();
    full_load(2, "reload");

    do_reset();
    rand_prog();
    got.delete();
    pulse_start();
    stream(0, 5, 2);
    pulse_start();
    stream(5, prog.size(), 2);
    wait_done();
    check_writes("start_in_load");
    pulse_start();
    chk("restart_done", {31'b0, done}, 32'd0);
    chk("restart_hold", {31'b0, core_hold}, 32'd1);
    rand_prog();
    got.delete();
    stream(0, prog.size(), 0);
    wait_done();
    check_writes("restart");

`ifdef IMEM_LOADER_CHECKSUM_EN
    for (int c = 0; c < 2; c++) begin
      do_reset();
      prog.delete();
      for (int k = 0; k < DEPTH; k++) prog.push_back(8'h01);
      prog.push_back(c == 0 ? 8'h28 : 8'h27);
      full_load(0, "checksum");
      chk("chk_err", {31'b0, chk_err}, 32'(c));
    end
`endif

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule

// File: doc/imem_loader.md
IMEM_LOADER -- requirements
Module: imem_loader

Interface
REQ-001 SHALL have parameter DEPTH_BYTES, default 40, instruction memory size in bytes; multiple of 4.
REQ-002 SHALL have parameter BASE_ADDR, default 32'h0000_0000, byte address of the first written word.
REQ-003 SHALL use one clock; reset is asynchronous and active-low.
REQ-004 SHALL have port clk, input, 1, rising-edge clock.
REQ-005 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-006 SHALL have port start, input, 1, single-cycle request to begin a load.
REQ-007 SHALL have port byte_in, input, 8, program byte stream.
REQ-008 SHALL have port byte_valid, input, 1, byte_in is valid.
REQ-009 SHALL have port byte_ready, output, 1, loader accepts byte_in this cycle.
REQ-010 SHALL have port wr_en, output, 1, one-cycle word write strobe to instruction memory.
REQ-011 SHALL have port wr_addr, output, 32, byte address of the word being written.
REQ-012 SHALL have port wr_data, output, 32, little-endian assembled word.
REQ-013 SHALL have port core_hold, output, 1, keeps the fetch stage stalled while memory contents are not valid.
REQ-014 SHALL have port done, output, 1, load complete; level signal.

Function
REQ-015 SHALL implement FSM states IDLE, LOAD, WRITE, DONE.
REQ-016 SHALL leave IDLE for LOAD on start; byte counter and word address reset to 0 and BASE_ADDR.
REQ-017 SHALL assert byte_ready only in LOAD; a byte transfers when byte_valid and byte_ready are both high on a rising clk edge.
REQ-018 SHALL place the k-th byte of a word (k=0..3) in wr_data bits [8k+7:8k].
REQ-019 SHALL enter WRITE on the 4th accepted byte and drive wr_en high for exactly that one cycle with stable wr_addr/wr_data.
REQ-020 SHALL advance wr_addr by 4 after each write and return to LOAD, or go to DONE after the write of byte DEPTH_BYTES-1.
REQ-021 SHALL give 1-cycle latency from the 4th byte handshake to wr_en; no bytes are accepted in WRITE.
REQ-022 SHALL ignore byte_valid when byte_ready is low; no byte is dropped or duplicated.
REQ-023 SHALL ignore start in LOAD and WRITE.
REQ-024 SHALL, on start in DONE, deassert done, reassert core_hold and restart at BASE_ADDR.
REQ-025 SHALL hold core_hold high in every state except DONE and drive done high only in DONE.
REQ-026 SHALL never let wr_addr exceed BASE_ADDR+DEPTH_BYTES-4.

Reset
REQ-027 SHALL on rst_n low enter IDLE immediately: byte_ready=0, wr_en=0, wr_addr=BASE_ADDR, wr_data=0, core_hold=1, done=0.
REQ-028 SHALL abort a load in progress on reset; partial word is discarded and no write is issued.

Configuration
REQ-029 SHALL support macro IMEM_LOADER_CHECKSUM_EN.
REQ-030 With the macro defined, SHALL add state CHECK and output chk_err (1 bit, reset 0).
REQ-031 SHALL, with the macro defined, accept one extra byte in CHECK after the final write, compare it to the mod-256 sum of all program bytes, set chk_err on mismatch, then enter DONE.
REQ-032 Without the macro, SHALL omit CHECK and chk_err; the FSM goes WRITE to DONE directly.
REQ-033 SHALL clear chk_err on start.

Structure
REQ-034 SHALL place the FSM state enum and the word-byte count constant (4) in a shared package, core_pkg.
REQ-035 SHALL be a single module with no sub-modules; the instruction memory write port is external.

Verification
REQ-036 Reset, then start, then bytes 12 34 56 78 -> wr_en one cycle, wr_addr=0x00, wr_data=0x78563412.
REQ-037 Full load of 40 bytes 9a bc de f0 repeated -> 10 writes at 0x00..0x24, each wr_data=0xf0debc9a, then done=1 and core_hold=0.
REQ-038 byte_valid toggled every other cycle and held high during WRITE -> identical write sequence, byte_ready=0 in WRITE.
REQ-039 rst_n pulled low after 6 bytes -> no further wr_en; a new start reloads from 0x00.
REQ-040 Start asserted in LOAD -> ignored; start in DONE -> done=0, core_hold=1, reload from 0x00.
REQ-041 Macro defined: 40 bytes of 0x01, then checksum 0x28 -> chk_err=0. With checksum 0x27 -> chk_err=1.
